// File: rtl/tdm_fir_pkg.sv
// Shared state encoding, index-width helper and round/narrow arithmetic for tdm_fir_filter.
package tdm_fir_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } fir_state_e;

    // Wide enough for any practical accumulator so the helper stays parameter-agnostic
    localparam int unsigned NARROW_W = 128;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

    // Round half up, arithmetic shift, then clamp (sat_en) or leave for the caller to truncate
    function automatic logic signed [NARROW_W-1:0] round_narrow(
        input  logic signed [NARROW_W-1:0] acc,
        input  int unsigned                shift,
        input  int unsigned                width,
        input  logic                       sat_en,
        output logic                       clipped
    );
        logic signed [NARROW_W-1:0] half;
        logic signed [NARROW_W-1:0] res;
        logic signed [NARROW_W-1:0] hi;
        logic signed [NARROW_W-1:0] lo;
        half = $signed(NARROW_W'(1) << (shift - 32'd1));
        res  = (acc + half) >>> shift;
        hi   = $signed((NARROW_W'(1) << (width - 32'd1)) - NARROW_W'(1));
        lo   = -hi - $signed(NARROW_W'(1));
        if (sat_en && (res > hi)) begin
            res     = hi;
            clipped = 1'b1;
        end else if (sat_en && (res < lo)) begin
            res     = lo;
            clipped = 1'b1;
        end else begin
            clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/tdm_fir_mac.sv
// Two-stage shared MAC: registered multiply, then accumulate with per-channel emit into holding registers.
// Build option TDM_FIR_SAT_EN: clamp out-of-range results and raise sticky sat; otherwise wrap.
module tdm_fir_mac
    import tdm_fir_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 24,
    parameter int COEFF_WIDTH  = 24,
    parameter int OUT_SHIFT    = 23,
    parameter int ACC_WIDTH    = 54,
    parameter int CH_W         = 3
) (
    input  logic                                  clk_i,
    input  logic                                  reset_ni,
    input  logic                                  clr,
    input  logic                                  valid,
    input  logic                                  last,
    input  logic [CH_W-1:0]                       ch,
    input  logic [DATA_WIDTH-1:0]                 sample,
    input  logic [COEFF_WIDTH-1:0]                coeff,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] hold,
    output logic                                  sat
);

`ifdef TDM_FIR_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif

    localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [PROD_W-1:0]    prod_r;
    logic                        prod_vld_r;
    logic                        prod_last_r;
    logic [CH_W-1:0]             prod_ch_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_sum_s;
    logic [DATA_WIDTH-1:0]       rnd_s;
    logic                        clip_s;

    // Stage 1: register the signed product together with its channel tag
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prod_r      <= '0;
            prod_vld_r  <= 1'b0;
            prod_last_r <= 1'b0;
            prod_ch_r   <= '0;
        end else begin
            prod_vld_r  <= valid;
            prod_last_r <= valid && last;
            prod_ch_r   <= ch;
            prod_r      <= $signed(sample) * $signed(coeff);
        end
    end

    // Running sum and its rounded/narrowed form for the emit at a channel's last tap
    always_comb begin
        acc_sum_s = acc_r + ACC_WIDTH'(prod_r);
        rnd_s     = DATA_WIDTH'(round_narrow(NARROW_W'(acc_sum_s), OUT_SHIFT, DATA_WIDTH,
                                             SAT_EN, clip_s));
    end

    // Stage 2: accumulate; on the last tap emit to the holding register and restart from zero
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            acc_r <= '0;
            hold  <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (prod_vld_r) begin
            if (prod_last_r) begin
                acc_r           <= '0;
                hold[prod_ch_r] <= rnd_s;
                sat             <= sat | clip_s;
            end else begin
                acc_r <= acc_sum_s;
            end
        end
    end

endmodule

// File: rtl/tdm_fir_filter.sv
// Multi-channel FIR sharing one pipelined MAC across all channels, each with its own circular delay line.
// Build option TDM_FIR_SAT_EN selects saturating output narrowing (default build wraps).
module tdm_fir_filter
    import tdm_fir_pkg::*;
#(
    parameter int NUM_CHANNELS = 8,
    parameter int DATA_WIDTH   = 24,
    parameter int COEFF_WIDTH  = 24,
    parameter int COEFF_LENGTH = 41,
    parameter int OUT_SHIFT    = 23,
    parameter int ACC_WIDTH    = DATA_WIDTH + COEFF_WIDTH + $clog2(COEFF_LENGTH)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_ni,
    input  logic                                    tick_i,
    input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [COEFF_LENGTH-1:0][COEFF_WIDTH-1:0] coeff_i,
    output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_o,
    output logic                                    tick_o,
    output logic                                    busy_o,
    output logic                                    overrun_o,
    output logic                                    sat_o,
    output logic [31:0]                             sample_count_o
);

    localparam int PTR_W = idx_width(COEFF_LENGTH);
    localparam int CH_W  = idx_width(NUM_CHANNELS);
    localparam logic [PTR_W-1:0] LAST_TAP = PTR_W'(COEFF_LENGTH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [PTR_W:0]   LEN_EXT  = (PTR_W + 1)'(COEFF_LENGTH);

    fir_state_e                              state_r;
    logic [PTR_W-1:0]                        clr_cnt_r;
    logic [PTR_W-1:0]                        wptr_r;
    logic [PTR_W-1:0]                        tap_r;
    logic [CH_W-1:0]                         ch_r;
    logic                                    drain_r;
    logic [PTR_W-1:0]                        wr_addr_s;
    logic [PTR_W-1:0]                        rd_addr_s;
    logic [PTR_W:0]                          rd_wrap_s;
    logic                                    accept_s;
    logic                                    wr_en_s;
    logic                                    mac_valid_s;
    logic                                    mac_last_s;
    logic [DATA_WIDTH-1:0]                   sample_s;
    logic [DATA_WIDTH-1:0]                   dline_r [NUM_CHANNELS][COEFF_LENGTH];
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] hold_s;

    // Frame acceptance, delay-line addressing (x[n-k] lives at wptr-k mod L) and MAC strobes
    always_comb begin
        accept_s    = (state_r == ST_IDLE) && tick_i;
        wr_en_s     = (state_r == ST_CLEAR) || accept_s;
        mac_valid_s = (state_r == ST_MAC);
        mac_last_s  = (tap_r == LAST_TAP);
        rd_wrap_s   = {1'b0, wptr_r} + LEN_EXT - {1'b0, tap_r};
        if (state_r == ST_CLEAR) begin
            wr_addr_s = clr_cnt_r;
        end else begin
            wr_addr_s = wptr_r;
        end
        if (wptr_r >= tap_r) begin
            rd_addr_s = wptr_r - tap_r;
        end else begin
            rd_addr_s = rd_wrap_s[PTR_W-1:0];
        end
        sample_s = dline_r[ch_r][rd_addr_s];
    end

    // Delay-line write port: zero-fill while clearing, capture every channel on an accepted frame
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                dline_r[c][wr_addr_s] <= (state_r == ST_CLEAR) ? '0 : data_i[c];
            end
        end
    end

    // Sequencer; DONE's publish/count/pointer actions are registered on entry so they show during DONE
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r        <= ST_CLEAR;
            clr_cnt_r      <= '0;
            wptr_r         <= '0;
            tap_r          <= '0;
            ch_r           <= '0;
            drain_r        <= 1'b0;
            data_o         <= '0;
            tick_o         <= 1'b0;
            busy_o         <= 1'b1;
            overrun_o      <= 1'b0;
            sample_count_o <= 32'd0;
        end else begin
            tick_o <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    if (clr_cnt_r == LAST_TAP) begin
                        clr_cnt_r <= '0;
                        busy_o    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        clr_cnt_r <= clr_cnt_r + PTR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (tick_i) begin
                        tap_r   <= '0;
                        ch_r    <= '0;
                        busy_o  <= 1'b1;
                        state_r <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (tick_i) overrun_o <= 1'b1;
                    if (tap_r == LAST_TAP) begin
                        tap_r <= '0;
                        if (ch_r == LAST_CH) begin
                            ch_r    <= '0;
                            state_r <= ST_DRAIN;
                        end else begin
                            ch_r <= ch_r + CH_W'(1);
                        end
                    end else begin
                        tap_r <= tap_r + PTR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (tick_i) overrun_o <= 1'b1;
                    if (drain_r) begin
                        drain_r        <= 1'b0;
                        data_o         <= hold_s;
                        tick_o         <= 1'b1;
                        busy_o         <= 1'b0;
                        sample_count_o <= sample_count_o + 32'd1;
                        wptr_r         <= (wptr_r == LAST_TAP) ? '0 : wptr_r + PTR_W'(1);
                        state_r        <= ST_DONE;
                    end else begin
                        drain_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (tick_i) overrun_o <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    clr_cnt_r <= '0;
                    busy_o    <= 1'b1;
                    state_r   <= ST_CLEAR;
                end
            endcase
        end
    end

    tdm_fir_mac #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .DATA_WIDTH   (DATA_WIDTH),
        .COEFF_WIDTH  (COEFF_WIDTH),
        .OUT_SHIFT    (OUT_SHIFT),
        .ACC_WIDTH    (ACC_WIDTH),
        .CH_W         (CH_W)
    ) u_mac (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .clr      (accept_s),
        .valid    (mac_valid_s),
        .last     (mac_last_s),
        .ch       (ch_r),
        .sample   (sample_s),
        .coeff    (coeff_i[tap_r]),
        .hold     (hold_s),
        .sat      (sat_o)
    );

endmodule

// File: tb/tb_tdm_fir_filter.sv
// Scoreboard bench for tdm_fir_filter: a direct-convolution model predicts every published frame.
`timescale 1ns/1ps
module tb_tdm_fir_filter;

    localparam int NCH = 8;
    localparam int DW  = 24;
    localparam int CW  = 24;
    localparam int L   = 41;
    localparam int SH  = 23;
    localparam int LAT = NCH * L + 3;

    typedef logic signed [63:0] val_t;
    typedef struct packed {
        logic [NCH-1:0][DW-1:0] val;
        logic [31:0]            cnt;
        logic                   sat;
        logic [31:0]            t0;
    } exp_t;

    logic                   clk      = 1'b0;
    logic                   reset_ni = 1'b0;
    logic                   tick_i   = 1'b0;
    logic [NCH-1:0][DW-1:0] data_i   = '0;
    logic [L-1:0][CW-1:0]   coeff_i  = '0;
    logic [NCH-1:0][DW-1:0] data_o;
    logic                   tick_o;
    logic                   busy_o;
    logic                   overrun_o;
    logic                   sat_o;
    logic [31:0]            sample_count_o;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     exp_cnt = 0;
    bit     exp_sat = 1'b0;
    longint hist [NCH][L];
    exp_t   sb [$];
    exp_t   mon_e;
    logic [NCH-1:0][DW-1:0] last_out = '0;

    tdm_fir_filter dut (
        .clk_i          (clk),
        .reset_ni       (reset_ni),
        .tick_i         (tick_i),
        .data_i         (data_i),
        .coeff_i        (coeff_i),
        .data_o         (data_o),
        .tick_o         (tick_o),
        .busy_o         (busy_o),
        .overrun_o      (overrun_o),
        .sat_o          (sat_o),
        .sample_count_o (sample_count_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input val_t obs, input val_t exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_out(input int c, output bit clip);
        longint acc, y, hi, lo;
        logic signed [DW-1:0] t;
        acc = 0;
        for (int k = 0; k < L; k++) acc += longint'($signed(coeff_i[k])) * hist[c][k];
        y  = (acc + (longint'(1) << (SH - 1))) >>> SH;
        hi = (longint'(1) << (DW - 1)) - 1;
        lo = -hi - 1;
`ifdef TDM_FIR_SAT_EN
        clip = (y > hi) || (y < lo);
        if (y > hi) y = hi;
        if (y < lo) y = lo;
`else
        clip = 1'b0;
        t = y[DW-1:0];
        y = longint'(t);
`endif
        return y;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int k = 0; k < L; k++) hist[c][k] = 0;
        exp_cnt = 0;
        exp_sat = 1'b0;
        sb.delete();
    endtask

    task automatic push_frame();
        exp_t   ent;
        bit     clip;
        longint y;
        for (int c = 0; c < NCH; c++) begin
            for (int k = L - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = longint'($signed(data_i[c]));
            y = model_out(c, clip);
            ent.val[c] = y[DW-1:0];
            if (clip) exp_sat = 1'b1;
        end
        exp_cnt++;
        ent.cnt = 32'(exp_cnt);
        ent.sat = exp_sat;
        ent.t0  = 32'(cyc);
        sb.push_back(ent);
    endtask

    task automatic send_tick(input bit accept);
        @(negedge clk);
        tick_i = 1'b1;
        if (accept) push_frame();
        @(negedge clk);
        tick_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_value("drain_timeout", sb.size(), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_value("clear_timeout", busy_o, 0);
    endtask

    task automatic check_reset_state(input string tag);
        for (int c = 0; c < NCH; c++) check_value({tag, "_data_o"}, $signed(data_o[c]), 0);
        check_value({tag, "_tick_o"}, tick_o, 0);
        check_value({tag, "_overrun_o"}, overrun_o, 0);
        check_value({tag, "_sat_o"}, sat_o, 0);
        check_value({tag, "_count"}, sample_count_o, 0);
        check_value({tag, "_busy_o"}, busy_o, 1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_ni = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        reset_ni = 1'b1;
        wait_idle();
    endtask

    // Scoreboard consumer: every tick_o must match the oldest predicted frame
    always @(negedge clk) begin
        if (tick_o) begin
            if (sb.size() == 0) begin
                check_value("spurious_tick_o", tick_o, 0);
            end else begin
                mon_e = sb.pop_front();
                for (int c = 0; c < NCH; c++)
                    check_value($sformatf("data_o[%0d]#%0d", c, mon_e.cnt),
                                $signed(data_o[c]), $signed(mon_e.val[c]));
                check_value("sample_count_o", sample_count_o, mon_e.cnt);
                check_value("sat_o", sat_o, mon_e.sat);
                check_value("latency", cyc - int'(mon_e.t0), LAT);
                last_out = mon_e.val;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, busy_hi;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset_ni = 1'b1;
        wait_idle();

        // Impulse through tap 0 on channel 0
        coeff_i    = '0;
        coeff_i[0] = 24'd8388607;
        for (int f = 0; f < 3; f++) begin
            data_i    = '0;
            data_i[0] = (f == 0) ? 24'd1000 : 24'd0;
            send_tick(1'b1);
            wait_drain();
        end

        // Pure 5-frame delay on channel 3
        apply_reset();
        coeff_i    = '0;
        coeff_i[5] = 24'd8388607;
        for (int f = 0; f < 7; f++) begin
            data_i    = '0;
            data_i[3] = (f == 0) ? -24'sd500 : 24'sd0;
            send_tick(1'b1);
            wait_drain();
        end

        // Random coefficients and samples, back-to-back frames
        for (int k = 0; k < L; k++) coeff_i[k] = CW'(int'($urandom_range(0, 2097152)) - 1048576);
        for (int f = 0; f < 5; f++) begin
            for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom);
            send_tick(1'b1);
            wait_drain();
        end

        // Frames 400 cycles apart: latency and busy window per frame
        for (int f = 0; f < 3; f++) begin
            for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom);
            send_tick(1'b1);
            busy_hi = 0;
            n = 0;
            while (!tick_o && n < 1000) begin
                if (busy_o) busy_hi++;
                @(negedge clk);
                n++;
            end
            check_value("tick_o_timeout", tick_o, 1);
            check_value("busy_cycles", busy_hi, NCH * L + 2);
            repeat (400 - LAT - 1) @(negedge clk);
        end

        // Overrun: a second tick during MAC is dropped
        for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom);
        send_tick(1'b1);
        repeat (98) @(negedge clk);
        for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom);
        send_tick(1'b0);
        wait_drain();
        check_value("overrun_set", overrun_o, 1);
        repeat (40) @(negedge clk);
        for (int c = 0; c < NCH; c++) check_value("data_o_hold", $signed(data_o[c]), $signed(last_out[c]));
        check_value("overrun_sticky", overrun_o, 1);

        // Reset in the middle of MAC, tick during CLEAR, then fresh history
        for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom);
        send_tick(1'b1);
        repeat (48) @(negedge clk);
        reset_ni = 1'b0;
        model_clear();
        #1;
        check_reset_state("midmac");
        @(negedge clk);
        reset_ni = 1'b1;
        n = 0;
        while (busy_o && n < 100) begin
            n++;
            tick_i = (n == 10);
            @(negedge clk);
        end
        tick_i = 1'b0;
        check_value("clear_busy_cycles", n, L);
        check_value("clear_tick_no_overrun", overrun_o, 0);
        coeff_i    = '0;
        coeff_i[0] = 24'd8388607;
        coeff_i[3] = -24'sd4194304;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < NCH; c++) data_i[c] = DW'($urandom_range(0, 200000));
            send_tick(1'b1);
            wait_drain();
        end

        // Full-scale inputs with full-scale taps: clamp or wrap depending on the build
        apply_reset();
        for (int k = 0; k < L; k++) coeff_i[k] = 24'h7FFFFF;
        for (int f = 0; f < 2 * L; f++) begin
            for (int c = 0; c < NCH; c++) data_i[c] = (f < L) ? 24'h7FFFFF : 24'h800000;
            send_tick(1'b1);
            wait_drain();
        end
        check_value("sat_final", sat_o, exp_sat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
